// File: rtl/bit_comparator_pkg.sv
// ---------------------------------------------------------------------------
// bit_comparator_pkg
//   Shared definitions for the bit_comparator block.
//   - DEFAULT_WIDTH : operand width used when the top is not overridden.
//   - cmp_result_e  : one-hot-free encoding of the whole-word compare result.
//     It is resolved combinationally and then expanded into the eq/gt/lt
//     flag registers.
// ---------------------------------------------------------------------------
package bit_comparator_pkg;

    localparam int DEFAULT_WIDTH = 1;

    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_GT = 2'd1,
        CMP_LT = 2'd2
    } cmp_result_e;

endpackage : bit_comparator_pkg

// File: rtl/bit_comparator_cell.sv
// ---------------------------------------------------------------------------
// bit_comparator_cell
//   Purely combinational single-bit slice of the comparator.
//   Ports:
//     a_i, b_i : operand bits at this position
//     gt_in    : a > b already decided by a more-significant bit
//     lt_in    : a < b already decided by a more-significant bit
//     s_o      : a_i ^ b_i (mismatch / half-add sum)
//     c_o      : a_i & b_i (both set / half-add carry)
//     gt_out   : a > b decided at this bit or above
//     lt_out   : a < b decided at this bit or above
// ---------------------------------------------------------------------------
module bit_comparator_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic gt_in,
    input  logic lt_in,
    output logic s_o,
    output logic c_o,
    output logic gt_out,
    output logic lt_out
);

    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;

    // A decision taken by a more-significant bit blocks the opposite flag,
    // so the first differing bit from the MSB wins.
    assign gt_out = gt_in | (~lt_in &  a_i & ~b_i);
    assign lt_out = lt_in | (~gt_in & ~a_i &  b_i);

endmodule : bit_comparator_cell

// File: rtl/bit_comparator.sv
// ---------------------------------------------------------------------------
// bit_comparator
//   Registered unsigned comparator / half-add cell, one cycle of latency.
//   Ports:
//     clk       : rising-edge clock
//     rst_n     : asynchronous active-low reset
//     in_valid  : capture a/b on this edge
//     a, b      : unsigned operands, WIDTH bits
//     S         : registered a ^ b
//     Cout      : registered a & b
//     eq/gt/lt  : registered whole-word unsigned compare (exactly one set
//                 after any capture, all zero in reset)
//     out_valid : high the cycle after a captured in_valid
//   Result registers hold when in_valid is low; out_valid follows in_valid.
// ---------------------------------------------------------------------------
module bit_comparator
    import bit_comparator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] Cout,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic             out_valid
);

    // Cascade index WIDTH is the MSB-side entry (nothing decided yet);
    // index 0 is the final whole-word decision out of the LSB cell.
    logic [WIDTH:0]   gt_chain;
    logic [WIDTH:0]   lt_chain;
    logic [WIDTH-1:0] s_next;
    logic [WIDTH-1:0] c_next;
    cmp_result_e      cmp_next;

    logic [WIDTH-1:0] s_reg;
    logic [WIDTH-1:0] c_reg;
    logic             eq_reg;
    logic             gt_reg;
    logic             lt_reg;
    logic             valid_reg;

    assign gt_chain[WIDTH] = 1'b0;
    assign lt_chain[WIDTH] = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            bit_comparator_cell u_cell (
                .a_i    (a[gi]),
                .b_i    (b[gi]),
                .gt_in  (gt_chain[gi+1]),
                .lt_in  (lt_chain[gi+1]),
                .s_o    (s_next[gi]),
                .c_o    (c_next[gi]),
                .gt_out (gt_chain[gi]),
                .lt_out (lt_chain[gi])
            );
        end
    endgenerate

    always_comb begin
        cmp_next = CMP_EQ;
        if (gt_chain[0]) begin
            cmp_next = CMP_GT;
        end else if (lt_chain[0]) begin
            cmp_next = CMP_LT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg     <= '0;
            c_reg     <= '0;
            eq_reg    <= 1'b0;
            gt_reg    <= 1'b0;
            lt_reg    <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= in_valid;
            if (in_valid) begin
                s_reg  <= s_next;
                c_reg  <= c_next;
                eq_reg <= (cmp_next == CMP_EQ);
                gt_reg <= (cmp_next == CMP_GT);
                lt_reg <= (cmp_next == CMP_LT);
            end
        end
    end

    assign S         = s_reg;
    assign Cout      = c_reg;
    assign eq        = eq_reg;
    assign gt        = gt_reg;
    assign lt        = lt_reg;
    assign out_valid = valid_reg;

endmodule : bit_comparator

// File: tb/tb_bit_comparator.sv
// ---------------------------------------------------------------------------
// tb_bit_comparator
//   Drives a WIDTH=1 and a WIDTH=4 instance from a shared clock, reset and
//   in_valid. Expected outputs come from a reference model using plain
//   arithmetic (^, &, ==, >, <) on the operands captured at each edge.
// ---------------------------------------------------------------------------
module tb_bit_comparator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [0:0] a1, b1;
    logic [3:0] a4, b4;

    logic [0:0] s1, c1;
    logic       eq1, gt1, lt1, ov1;
    logic [3:0] s4, c4;
    logic       eq4, gt4, lt4, ov4;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    // reference model state
    logic [0:0] m1_s, m1_c;
    logic       m1_eq, m1_gt, m1_lt;
    logic [3:0] m4_s, m4_c;
    logic       m4_eq, m4_gt, m4_lt;
    logic       m_ov;

    always #5 clk = ~clk;

    bit_comparator #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a1), .b(b1), .S(s1), .Cout(c1),
        .eq(eq1), .gt(gt1), .lt(lt1), .out_valid(ov1)
    );

    bit_comparator #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a4), .b(b4), .S(s4), .Cout(c4),
        .eq(eq4), .gt(gt4), .lt(lt4), .out_valid(ov4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m1_s = '0; m1_c = '0; m1_eq = 0; m1_gt = 0; m1_lt = 0;
        m4_s = '0; m4_c = '0; m4_eq = 0; m4_gt = 0; m4_lt = 0;
        m_ov = 0;
    endtask

    task automatic model_edge();
        m_ov = in_valid;
        if (in_valid) begin
            m1_s = a1 ^ b1; m1_c = a1 & b1;
            m1_eq = (a1 == b1); m1_gt = (a1 > b1); m1_lt = (a1 < b1);
            m4_s = a4 ^ b4; m4_c = a4 & b4;
            m4_eq = (a4 == b4); m4_gt = (a4 > b4); m4_lt = (a4 < b4);
        end
    endtask

    task automatic check_all(input string ph);
        check({ph, " w1 S"},    32'(s1),  32'(m1_s));
        check({ph, " w1 Cout"}, 32'(c1),  32'(m1_c));
        check({ph, " w1 eq"},   32'(eq1), 32'(m1_eq));
        check({ph, " w1 gt"},   32'(gt1), 32'(m1_gt));
        check({ph, " w1 lt"},   32'(lt1), 32'(m1_lt));
        check({ph, " w1 ov"},   32'(ov1), 32'(m_ov));
        check({ph, " w4 S"},    32'(s4),  32'(m4_s));
        check({ph, " w4 Cout"}, 32'(c4),  32'(m4_c));
        check({ph, " w4 eq"},   32'(eq4), 32'(m4_eq));
        check({ph, " w4 gt"},   32'(gt4), 32'(m4_gt));
        check({ph, " w4 lt"},   32'(lt4), 32'(m4_lt));
        check({ph, " w4 ov"},   32'(ov4), 32'(m_ov));
    endtask

    // One transaction: drive on the falling edge, model the rising edge,
    // sample 1 time unit after it.
    task automatic step(input string ph, input logic v, input logic [0:0] x1, input logic [0:0] y1,
                        input logic [3:0] x4, input logic [3:0] y4);
        @(negedge clk);
        in_valid = v; a1 = x1; b1 = y1; a4 = x4; b4 = y4;
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        n_txn++;
        $display("txn %0d %s v=%0b a1=%0h b1=%0h a4=%0h b4=%0h -> S4=%0h C4=%0h eq/gt/lt=%0b%0b%0b ov=%0b",
                 n_txn, ph, v, x1, y1, x4, y4, s4, c4, eq4, gt4, lt4, ov4);
        check_all(ph);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0;
        a1 = '0; b1 = '0; a4 = '0; b4 = '0;
        model_reset();

        // reset state while rst_n held low, even with in_valid asserted
        #1;
        check_all("reset");
        step("reset_hold", 1'b1, 1'b1, 1'b0, 4'hf, 4'h0);

        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 exhaustive, WIDTH=4 ordering and equality, back-to-back
        step("b2b0", 1'b1, 1'b0, 1'b0, 4'b1000, 4'b0111);
        step("b2b1", 1'b1, 1'b0, 1'b1, 4'b0101, 4'b0110);
        step("b2b2", 1'b1, 1'b1, 1'b0, 4'b0110, 4'b0110);
        step("b2b3", 1'b1, 1'b1, 1'b1, 4'b0011, 4'b0011);

        // hold with toggling operands
        step("hold0", 1'b0, 1'b1, 1'b0, 4'hf, 4'h1);
        step("hold1", 1'b0, 1'b0, 1'b1, 4'h2, 4'he);
        step("hold2", 1'b0, 1'b1, 1'b0, 4'h9, 4'h4);

        // boundary operands
        step("bnd0", 1'b1, 1'b0, 1'b0, 4'hf, 4'hf);
        step("bnd1", 1'b1, 1'b0, 1'b0, 4'h0, 4'hf);
        step("bnd2", 1'b1, 1'b0, 1'b0, 4'hf, 4'h0);
        step("bnd3", 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);

        // randomized traffic
        for (int i = 0; i < 150; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                 4'($urandom), 4'($urandom));
        end

        // mid-cycle reset while out_valid is high: outputs clear without a clock edge
        step("pre_rst", 1'b1, 1'b1, 1'b1, 4'h9, 4'h3);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        step("rst_low", 1'b1, 1'b1, 1'b0, 4'h7, 4'h2);

        // release, then first edge captures a=1,b=0
        @(negedge clk);
        rst_n = 1'b1;
        step("release", 1'b1, 1'b1, 1'b0, 4'h1, 4'h0);
        step("idle", 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_bit_comparator

// File: doc/bit_comparator.md
Name: bit_comparator

Overview:
- Registered, parameterizable unsigned comparator / half-add cell. Per clock it produces two bitwise vectors, S = a XOR b (difference/mismatch) and Cout = a AND b (carry/both-set), plus whole-word eq/gt/lt flags.
- Sits in arithmetic/compare datapaths as a one-cycle-latency leaf block.
- With WIDTH=1 it behaves as a registered half adder, where S is the sum and Cout is the carry.

Parameters:
- WIDTH, 1, operand width in bits (must be ≥1).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies a/b for capture this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- S  output  WIDTH  registered bitwise a XOR b.
- Cout  output  WIDTH  registered bitwise a AND b.
- eq  output  1  registered (a == b).
- gt  output  1  registered (a > b), unsigned.
- lt  output  1  registered (a < b), unsigned.
- out_valid  output  1  high the cycle after a captured in_valid.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- Reset (rst_n=0, immediate, independent of clk):
  - S=0, Cout=0, eq=0, gt=0, lt=0, out_valid=0.
  - Deassertion takes effect on the next rising clk edge.
- Latency: 1 cycle. At a rising edge with in_valid=1, all result registers load from the a/b values present before the edge, and out_valid goes to 1.
- At a rising edge with in_valid=0:
  - S, Cout, eq, gt and lt hold their previous values.
  - out_valid goes to 0.
- Throughput: one operation per cycle. No backpressure and no ready signal.
- Flags: exactly one of eq, gt, lt is 1 after any valid capture. All three are 0 only in the reset state.
- Comparison is unsigned, with MSB-first priority: the first differing bit from the MSB decides gt or lt. If no bit differs, eq=1.
- Identities that hold after every valid capture:
  - eq = ~|S.
  - Cout | S equals a | b bitwise.
- Reset mid-stream: any in-flight result is discarded and out_valid drops immediately. The first valid capture after release produces a normal result.
- Inputs are sampled only at clock edges. Input glitches between edges have no effect.
- No X propagation from the reset state: all registers have defined reset values.

Decomposition:
- Package bit_comparator_pkg:
  - localparam DEFAULT_WIDTH=1.
  - Enum cmp_result_e {CMP_EQ, CMP_GT, CMP_LT}, used internally to encode the flags before registering.
- One sub-module, bit_comparator_cell, per bit:
  - Inputs: a_i, b_i, and cascade gt_in/lt_in from the more-significant neighbour.
  - Outputs: s_o = a_i^b_i, c_o = a_i&b_i, and gt_out/lt_out. gt_out = gt_in | (~lt_in & a_i & ~b_i); lt_out is symmetric.
  - The top level chains WIDTH cells MSB→LSB with gt/lt cascade inputs tied to 0 at the MSB.
  - Registering happens in the top level only.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with out_valid=1 → all outputs 0 immediately, without waiting for clk; they stay 0 until the first valid capture.
- WIDTH=1 exhaustive, in_valid=1, a/b over 00, 01, 10, 11 on successive cycles. One cycle later each gives:
  - 00 → S=0 Cout=0 eq=1.
  - 01 → S=1 Cout=0 lt=1.
  - 10 → S=1 Cout=0 gt=1.
  - 11 → S=0 Cout=1 eq=1.
- WIDTH=4 ordering:
  - a=4'b1000, b=4'b0111 → gt=1, S=4'b1111, Cout=0.
  - a=4'b0101, b=4'b0110 → lt=1, S=4'b0011, Cout=4'b0100.
- Hold: capture a=3, b=3 (WIDTH=4), then in_valid=0 for 3 cycles with a/b toggling → eq=1 and S=0 held, out_valid=1 for one cycle then 0.
- Back-to-back: in_valid=1 for 4 consecutive cycles with distinct operand pairs → results appear in order one cycle delayed, out_valid continuously 1.
- Reset release: deassert rst_n, then apply a=1, b=0 (WIDTH=1) with in_valid=1 on the first edge → next cycle S=1 Cout=0 gt=1 out_valid=1.
